// File: rtl/systolic_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types and helpers for the streaming systolic matrix
//               multiplier: FSM state encoding, latency helper and the
//               result saturation function.
// Revision    : 1.0 - initial streaming release
// ============================================================================
package systolic_pkg;

    // Transaction FSM encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FORMAT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Accept-to-out_valid latency in cycles for an M x N x P product
    function automatic int unsigned latency(input int unsigned m,
                                            input int unsigned n,
                                            input int unsigned p);
        return m + n + p;
    endfunction

    // Latency of the default 8 x 8 x 8 configuration
    localparam int unsigned C_LATENCY = latency(8, 8, 8);

    // Saturation result: clipped element (low dw bits meaningful) and clip flag
    typedef struct packed {
        logic [63:0] elem;
        logic        clip;
    } sat_res_t;

    // Clip a sign-/zero-extended accumulator value to a dw-bit element range
    function automatic sat_res_t saturate(input logic signed [63:0] acc,
                                          input logic               signed_mode,
                                          input int unsigned        dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        if (signed_mode) begin
            hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (dw - 1));
        end else begin
            hi = (64'sd1 <<< dw) - 64'sd1;
            lo = 64'sd0;
        end
        r.clip = 1'b1;
        if (acc > hi) begin
            r.elem = hi;
        end else if (acc < lo) begin
            r.elem = lo;
        end else begin
            r.elem = acc;
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : systolic_pe
// Description : Output-stationary processing element. Forwards a to the right
//               and b downward through registers and accumulates a*b,
//               sign- or zero-extended to ACC_WIDTH.
// Revision    : 1.0 - initial streaming release
// ============================================================================
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [ACC_WIDTH-1:0] w_a_ext;
    logic [ACC_WIDTH-1:0] w_b_ext;
    logic [ACC_WIDTH-1:0] w_prod;

    // Product kept modulo 2^ACC_WIDTH, which is exact for both signednesses
    assign w_a_ext = {{(ACC_WIDTH-DATA_WIDTH){signed_mode & a_in[DATA_WIDTH-1]}}, a_in};
    assign w_b_ext = {{(ACC_WIDTH-DATA_WIDTH){signed_mode & b_in[DATA_WIDTH-1]}}, b_in};
    assign w_prod  = w_a_ext * w_b_ext;

    // Operand forwarding and multiply-accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + w_prod;
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_matmul_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : systolic_matmul_stream
// Description : Streaming C = A x B on an M x P output-stationary PE grid with
//               valid/ready on both sides, per-transaction signed/unsigned and
//               wrap/saturate modes, and a per-element saturation mask.
// Revision    : 1.0 - initial streaming release
// ============================================================================
module systolic_matmul_stream
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 8,
    parameter int N          = 8,
    parameter int P          = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [M*N*DATA_WIDTH-1:0]    matrix_a,
    input  logic [N*P*DATA_WIDTH-1:0]    matrix_b,
    input  logic                         signed_mode,
    input  logic                         sat_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [M*P*DATA_WIDTH-1:0]    result_c,
    output logic [M*P-1:0]               sat_mask
);

    // Step 0 primes the registered skew feed, so RUN lasts LATENCY-1 cycles
    // and the last product lands on the final RUN edge; FORMAT adds one more.
    localparam int LATENCY = int'(latency(M, N, P));
    localparam int TERM    = LATENCY - 2;
    localparam int CW      = $clog2(LATENCY);

    if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(N)) begin : g_acc_too_narrow
        $error("ACC_WIDTH is narrower than 2*DATA_WIDTH+clog2(N)");
    end
    if (ACC_WIDTH > 63) begin : g_acc_too_wide
        $error("ACC_WIDTH must not exceed 63 bits for the formatting path");
    end

    state_t                        r_state;
    state_t                        w_next;
    logic [CW-1:0]                 r_cnt;
    logic                          w_term;
    logic                          w_accept;
    logic                          w_en;
    logic [M*N*DATA_WIDTH-1:0]     r_a;
    logic [N*P*DATA_WIDTH-1:0]     r_b;
    logic                          r_signed;
    logic                          r_sat;
    logic [DATA_WIDTH-1:0]         r_feed_a [M];
    logic [DATA_WIDTH-1:0]         r_feed_b [P];

    wire  [DATA_WIDTH-1:0]         w_a   [M][P+1];
    wire  [DATA_WIDTH-1:0]         w_b   [M+1][P];
    wire  [ACC_WIDTH-1:0]          w_acc [M][P];
    wire  [M*P*DATA_WIDTH-1:0]     w_result;
    wire  [M*P-1:0]                w_mask;

    assign w_term = (r_cnt == CW'(TERM));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (w_term) w_next = FORMAT;
            FORMAT:  w_next = HOLD;
            HOLD:    if (out_ready) w_next = in_valid ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake and grid control outputs
    always_comb begin
        in_ready  = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
        out_valid = (r_state == HOLD);
        w_accept  = in_valid && in_ready;
        w_en      = (r_state == RUN);
    end

    // Step counter: counts RUN cycles, parked at zero elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == RUN) && !w_term) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Operand and mode capture on the accepting edge only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_sat    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= matrix_a;
            r_b      <= matrix_b;
            r_signed <= signed_mode;
            r_sat    <= sat_mode;
        end
    end

    // Skewed edge feed: row i / column j sees element (step - i / step - j)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) r_feed_a[i] <= '0;
            for (int j = 0; j < P; j++) r_feed_b[j] <= '0;
        end else begin
            for (int i = 0; i < M; i++) begin
                if ((r_state == RUN) && (int'(r_cnt) >= i) && (int'(r_cnt) < i + N)) begin
                    r_feed_a[i] <= r_a[(i*N + int'(r_cnt) - i)*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    r_feed_a[i] <= '0;
                end
            end
            for (int j = 0; j < P; j++) begin
                if ((r_state == RUN) && (int'(r_cnt) >= j) && (int'(r_cnt) < j + N)) begin
                    r_feed_b[j] <= r_b[((int'(r_cnt) - j)*P + j)*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    r_feed_b[j] <= '0;
                end
            end
        end
    end

    // Result registers, loaded once per transaction in FORMAT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_c <= '0;
            sat_mask <= '0;
        end else if (r_state == FORMAT) begin
            result_c <= w_result;
            sat_mask <= w_mask;
        end
    end

    for (genvar gj = 0; gj < P; gj++) begin : g_top_feed
        assign w_b[0][gj] = r_feed_b[gj];
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_row
        assign w_a[gi][0] = r_feed_a[gi];
        for (genvar gj = 0; gj < P; gj++) begin : g_col
            logic signed [63:0] w_ext;
            sat_res_t           w_sat;

            systolic_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk         (clk),
                .rst_n       (rst_n),
                .clr         (w_accept),
                .en          (w_en),
                .signed_mode (r_signed),
                .a_in        (w_a[gi][gj]),
                .b_in        (w_b[gi][gj]),
                .a_out       (w_a[gi][gj+1]),
                .b_out       (w_b[gi+1][gj]),
                .acc         (w_acc[gi][gj])
            );

            assign w_ext = {{(64-ACC_WIDTH){r_signed & w_acc[gi][gj][ACC_WIDTH-1]}}, w_acc[gi][gj]};
            assign w_sat = saturate(w_ext, r_signed, DATA_WIDTH);
            assign w_result[(gi*P+gj)*DATA_WIDTH +: DATA_WIDTH] =
                r_sat ? w_sat.elem[DATA_WIDTH-1:0] : w_acc[gi][gj][DATA_WIDTH-1:0];
            assign w_mask[gi*P+gj] = r_sat & w_sat.clip;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_matmul_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_systolic_matmul_stream
// Description : Self-checking bench for systolic_matmul_stream (8x8x8) with an
//               integer-arithmetic reference model.
// Revision    : 1.0 - initial streaming release
// ============================================================================
module tb_systolic_matmul_stream;

    localparam int DW  = 8;
    localparam int M   = 8;
    localparam int N   = 8;
    localparam int P   = 8;
    localparam int LAT = M + N + P;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [511:0]    matrix_a;
    logic [511:0]    matrix_b;
    logic            signed_mode;
    logic            sat_mode;
    logic            out_valid;
    logic            out_ready;
    logic [511:0]    result_c;
    logic [63:0]     sat_mask;

    int n_assert = 0;
    int n_fail   = 0;

    systolic_matmul_stream #(
        .DATA_WIDTH (DW),
        .M          (M),
        .N          (N),
        .P          (P)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .matrix_a    (matrix_a),
        .matrix_b    (matrix_b),
        .signed_mode (signed_mode),
        .sat_mode    (sat_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_c    (result_c),
        .sat_mask    (sat_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_mask(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_mat();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    // Reference: integer matrix product followed by element formatting
    task automatic model(input logic [511:0] a, input logic [511:0] b,
                         input bit sg, input bit st,
                         output logic [511:0] c, output logic [63:0] m);
        logic [7:0] ae, be, e;
        int         av, bv, sum;
        bit         clip;
        c = '0;
        m = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < P; j++) begin
                sum = 0;
                for (int k = 0; k < N; k++) begin
                    ae = a[(i*N + k)*8 +: 8];
                    be = b[(k*P + j)*8 +: 8];
                    av = sg ? {{24{ae[7]}}, ae} : {24'd0, ae};
                    bv = sg ? {{24{be[7]}}, be} : {24'd0, be};
                    sum += av * bv;
                end
                e    = sum[7:0];
                clip = 1'b0;
                if (st) begin
                    if (sg) begin
                        if (sum > 127)       begin e = 8'h7F; clip = 1'b1; end
                        else if (sum < -128) begin e = 8'h80; clip = 1'b1; end
                    end else if (sum > 255)  begin e = 8'hFF; clip = 1'b1; end
                end
                c[(i*P + j)*8 +: 8] = e;
                m[i*P + j]          = clip;
            end
        end
    endtask

    // Present an operand pair, complete the input handshake, then scramble inputs
    task automatic send(input logic [511:0] a, input logic [511:0] b, input bit sg, input bit st);
        @(negedge clk);
        matrix_a    = a;
        matrix_b    = b;
        signed_mode = sg;
        sat_mode    = st;
        in_valid    = 1'b1;
        chk_bit("in_ready_idle", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        matrix_a    = rand_mat();
        matrix_b    = rand_mat();
        signed_mode = ~sg;
        sat_mode    = ~st;
    endtask

    // Count edges after the accepting edge until out_valid (bounded)
    task automatic wait_out(output int lat);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) chk_bit("in_ready_busy", in_ready, 1'b0);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk_bit("out_valid_retired", out_valid, 1'b0);
    endtask

    task automatic txn(input string tag, input logic [511:0] a, input logic [511:0] b,
                       input bit sg, input bit st);
        logic [511:0] ec;
        logic [63:0]  em;
        int           lat;
        model(a, b, sg, st, ec, em);
        send(a, b, sg, st);
        wait_out(lat);
        chk_int({tag, "_latency"}, lat, LAT);
        chk_vec({tag, "_result"}, result_c, ec);
        chk_mask({tag, "_mask"}, sat_mask, em);
        retire();
    endtask

    initial begin
        logic [511:0] a, b, a2, b2, ec, snap, cst;
        logic [63:0]  em;
        int           lat, spurious;

        in_valid    = 1'b0;
        out_ready   = 1'b0;
        matrix_a    = '0;
        matrix_b    = '0;
        signed_mode = 1'b0;
        sat_mode    = 1'b0;
        rst_n       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_vec("rst_result", result_c, '0);
        chk_mask("rst_mask", sat_mask, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity A, B = 0..63, signed wrap: C must equal B
        for (int i = 0; i < M; i++)
            for (int k = 0; k < N; k++)
                a[(i*N + k)*8 +: 8] = (i == k) ? 8'd1 : 8'd0;
        for (int e = 0; e < 64; e++) b[e*8 +: 8] = 8'(e);
        txn("identity", a, b, 1'b1, 1'b0);
        chk_vec("identity_equals_b", result_c, b);

        // Legacy equivalence: random signed operands, wrap mode
        for (int t = 0; t < 3; t++) txn("legacy", rand_mat(), rand_mat(), 1'b1, 1'b0);

        // Signed saturation, positive and negative
        a   = {64{8'd127}};
        b   = {64{8'd127}};
        cst = {64{8'h7F}};
        txn("sat_pos", a, b, 1'b1, 1'b1);
        chk_vec("sat_pos_const", result_c, cst);
        chk_mask("sat_pos_mask_ones", sat_mask, '1);
        b   = {64{8'h80}};
        cst = {64{8'h80}};
        txn("sat_neg", a, b, 1'b1, 1'b1);
        chk_vec("sat_neg_const", result_c, cst);

        // Unsigned saturate and unsigned wrap of all-0xFF operands
        a   = {64{8'hFF}};
        b   = {64{8'hFF}};
        cst = {64{8'hFF}};
        txn("usat", a, b, 1'b0, 1'b1);
        chk_vec("usat_const", result_c, cst);
        chk_mask("usat_mask_ones", sat_mask, '1);
        cst = {64{8'h08}};
        txn("uwrap", a, b, 1'b0, 1'b0);
        chk_vec("uwrap_const", result_c, cst);

        // Random mode mix
        for (int t = 0; t < 4; t++) txn("mix", rand_mat(), rand_mat(), t[0], t[1]);

        // Backpressure then simultaneous retire/accept
        a  = rand_mat();
        b  = rand_mat();
        a2 = rand_mat();
        b2 = rand_mat();
        model(a, b, 1'b1, 1'b1, ec, em);
        send(a, b, 1'b1, 1'b1);
        wait_out(lat);
        chk_int("bp_latency", lat, LAT);
        chk_vec("bp_result", result_c, ec);
        snap = result_c;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk_vec("bp_stable", result_c, snap);
            chk_bit("bp_in_ready_low", in_ready, 1'b0);
            chk_bit("bp_out_valid_high", out_valid, 1'b1);
        end
        @(negedge clk);
        matrix_a    = a2;
        matrix_b    = b2;
        signed_mode = 1'b0;
        sat_mode    = 1'b1;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        #1;
        chk_bit("b2b_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        matrix_a  = rand_mat();
        sat_mode  = 1'b0;
        chk_bit("b2b_out_valid_drop", out_valid, 1'b0);
        model(a2, b2, 1'b0, 1'b1, ec, em);
        wait_out(lat);
        chk_int("b2b_latency", lat, LAT);
        chk_vec("b2b_result", result_c, ec);
        chk_mask("b2b_mask", sat_mask, em);

        // Reset mid-RUN of the next transaction (previous result still held)
        retire();
        send(rand_mat(), rand_mat(), 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_vec("rst_run_result", result_c, '0);
        chk_mask("rst_run_mask", sat_mask, '0);
        chk_bit("rst_run_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_bit("rst_run_in_ready", in_ready, 1'b1);
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious++;
        end
        chk_int("rst_run_no_spurious", spurious, 0);

        // Recovery after abort
        txn("recover", rand_mat(), rand_mat(), 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
